// File: rtl/sf_camera_pkg.sv
// Shared definitions for the sf_camera pixel-bus blocks: FSM state encoding,
// byte ordering on the bus and the widths of the geometry/frame/size counters.
package sf_camera_pkg;

  localparam int unsigned GEOM_W  = 16;
  localparam int unsigned FRAME_W = 32;
  localparam int unsigned SIZE_W  = 24;

  // Words leave the buffer most-significant byte first.
  localparam logic MSB_FIRST = 1'b1;

  // Explicit encodings keep the legacy state numbering.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VBLANK = 3'd1,
    ROW    = 3'd2,
    HBLANK = 3'd3,
    FEND   = 3'd4
  } tx_state_t;

  // Byte idx (0 = first on the bus) of a buffered word.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [1:0] lane;
    lane = MSB_FIRST ? (2'd3 - idx) : idx;
    return word[{lane, 3'b000} +: 8];
  endfunction

  // Blanking lengths count ticks; zero still costs one tick.
  function automatic logic [GEOM_W-1:0] blank_reload(input logic [GEOM_W-1:0] n);
    return (n == '0) ? '0 : n - 16'd1;
  endfunction

endpackage

// File: rtl/sf_camera_tx_buffer.sv
// Single-clock word FIFO for the camera transmitter. Show-ahead read port:
// head always presents the oldest word. Pushes while full and pops while
// empty are ignored; a simultaneous push and pop leaves the count unchanged.
module sf_camera_tx_buffer
  import sf_camera_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [31:0]            push_data,
  input  logic                   pop,
  output logic [31:0]            head,
  output logic [BUFFER_SIZE:0]   count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned DEPTH = 1 << BUFFER_SIZE;

  logic [31:0]            mem [DEPTH];
  logic [BUFFER_SIZE-1:0] wr_ptr;
  logic [BUFFER_SIZE-1:0] rd_ptr;
  logic [BUFFER_SIZE:0]   cnt;
  logic                   do_push;
  logic                   do_pop;

  assign empty   = (cnt == '0);
  assign full    = cnt[BUFFER_SIZE];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Storage array write; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sf_camera_tx.sv
// sf_camera pixel-bus transmitter. Buffers 32-bit words from a write-FIFO
// handshake and serialises them MSB-byte-first onto an 8-bit bus with a
// clk/2 pixel clock and vsync/hsync framing. Bus outputs change only on the
// pixel-clock falling edge ("tick") so they are stable at its rising edge.
// Optional feature macro: SF_CAMERA_TX_TEST_PATTERN_EN (generated row data).
module sf_camera_tx
  import sf_camera_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic               i_reset_counts,
  input  logic [GEOM_W-1:0]  i_bytes_per_row,
  input  logic [GEOM_W-1:0]  i_rows_per_frame,
  input  logic [GEOM_W-1:0]  i_hblank,
  input  logic [GEOM_W-1:0]  i_vblank,
  input  logic               i_test_pattern,
  output logic               o_busy,
  output logic               o_underrun,
  output logic [FRAME_W-1:0] o_frame_count,
  output logic               o_wfifo_ready,
  input  logic               i_wfifo_activate,
  input  logic               i_wfifo_strobe,
  input  logic [31:0]        i_wfifo_data,
  output logic [SIZE_W-1:0]  o_wfifo_size,
  output logic               o_pix_clk,
  output logic               o_vsync,
  output logic               o_hsync,
  output logic [7:0]         o_pix_data
);

  localparam int unsigned DEPTH = 1 << BUFFER_SIZE;
  localparam int unsigned BLOCK = 1 << (BUFFER_SIZE - 1);
  localparam logic [BUFFER_SIZE:0] READY_MAX = (BUFFER_SIZE + 1)'(DEPTH - BLOCK);

  // Buffer interface
  logic [31:0]          buf_head;
  logic [BUFFER_SIZE:0] buf_count;
  logic                 buf_empty;
  logic                 buf_full;
  logic                 buf_push;
  logic                 buf_pop;

  // Timing and state
  logic                 pix_clk_q;
  logic                 tick;
  tx_state_t            state_q;
  logic [GEOM_W-1:0]    timer_q;
  logic [GEOM_W-1:0]    col_q;
  logic [GEOM_W-1:0]    row_q;
  logic                 vsync_q;
  logic                 hsync_q;
  logic [7:0]           data_q;
  logic                 busy_q;
  logic                 underrun_q;
  logic [FRAME_W-1:0]   frame_cnt_q;

  // Per-frame configuration, captured at VBLANK entry
  logic [GEOM_W-1:0]    bytes_q;
  logic [GEOM_W-1:0]    rows_q;
  logic [GEOM_W-1:0]    hblank_q;
  logic                 tp_q;

  // Start decision and byte generation
  logic                 tp_in;
  logic [GEOM_W-1:0]    bpr_masked;
  logic [31:0]          have_bytes;
  logic [31:0]          need_bytes;
  logic                 start_ok;
  logic                 load_cfg;
  logic                 row_done;
  logic                 last_row;
  logic                 emit;
  logic [GEOM_W-1:0]    emit_col;
  logic [7:0]           tp_byte;
  logic [7:0]           buf_byte;
  logic [7:0]           pix_byte;
  logic                 underrun_evt;

`ifdef SF_CAMERA_TX_TEST_PATTERN_EN
  assign tp_in = i_test_pattern;
`else
  // Input kept for port compatibility; generated data is not built in.
  assign tp_in = i_test_pattern & 1'b0;
`endif

  sf_camera_tx_buffer #(
    .BUFFER_SIZE(BUFFER_SIZE)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (i_wfifo_data),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  assign buf_push      = i_wfifo_activate && i_wfifo_strobe && !buf_full;
  assign o_wfifo_ready = !i_wfifo_activate && (buf_count <= READY_MAX);
  assign o_wfifo_size  = SIZE_W'(BLOCK);

  // Row length is whole words; the two low byte-count bits are dropped.
  assign bpr_masked = i_bytes_per_row & 16'hFFFC;
  assign have_bytes = 32'({buf_count, 2'b00});
  assign need_bytes = 32'(bpr_masked);
  assign start_ok   = i_enable && (bpr_masked != '0) && (i_rows_per_frame != '0) &&
                      (tp_in || (have_bytes >= need_bytes));
  assign tick       = pix_clk_q;
  assign load_cfg   = tick && start_ok && ((state_q == IDLE) || (state_q == FEND));
  assign row_done   = (col_q == bytes_q - 16'd1);
  assign last_row   = (row_q == rows_q - 16'd1);

  // Decide whether this tick drives a row byte, and which column it is.
  always_comb begin
    emit     = 1'b0;
    emit_col = '0;
    if (tick) begin
      unique case (state_q)
        VBLANK:  emit = (timer_q == '0);
        HBLANK:  emit = (timer_q == '0);
        ROW: begin
          emit     = !row_done;
          emit_col = col_q + 16'd1;
        end
        default: emit = 1'b0;
      endcase
    end
  end

  assign tp_byte      = emit_col[7:0] ^ row_q[7:0];
  assign buf_byte     = buf_empty ? '0 : word_byte(buf_head, emit_col[1:0]);
  assign pix_byte     = tp_q ? tp_byte : buf_byte;
  assign underrun_evt = emit && !tp_q && buf_empty;
  assign buf_pop      = emit && !tp_q && !buf_empty && (emit_col[1:0] == 2'd3);

  // Pixel clock runs at clk/2 continuously.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_clk_q <= 1'b0;
    end else begin
      pix_clk_q <= ~pix_clk_q;
    end
  end

  // Capture frame geometry once per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      bytes_q  <= '0;
      rows_q   <= '0;
      hblank_q <= '0;
      tp_q     <= 1'b0;
    end else if (load_cfg) begin
      bytes_q  <= bpr_masked;
      rows_q   <= i_rows_per_frame;
      hblank_q <= i_hblank;
      tp_q     <= tp_in;
    end
  end

  // Frame sequencer and bus output registers, advanced on ticks only.
  // Frame (re)start is handled ahead of the case so IDLE and FEND share it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else if (tick) begin
      if (emit) begin
        hsync_q <= 1'b1;
        data_q  <= pix_byte;
        col_q   <= emit_col;
      end
      if (load_cfg) begin
        state_q <= VBLANK;
        busy_q  <= 1'b1;
        timer_q <= blank_reload(i_vblank);
        row_q   <= '0;
      end
      unique case (state_q)
        IDLE: begin
        end
        VBLANK: begin
          if (timer_q == '0) begin
            vsync_q <= 1'b1;
            state_q <= ROW;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        ROW: begin
          if (row_done) begin
            hsync_q <= 1'b0;
            data_q  <= '0;
            if (last_row) begin
              state_q <= FEND;
            end else begin
              row_q   <= row_q + 16'd1;
              timer_q <= blank_reload(hblank_q);
              state_q <= HBLANK;
            end
          end
        end
        HBLANK: begin
          if (timer_q == '0) begin
            state_q <= ROW;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        FEND: begin
          vsync_q <= 1'b0;
          if (!load_cfg) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status counters; a clear request beats a same-cycle event.
  always_ff @(posedge clk) begin
    if (rst || i_reset_counts) begin
      frame_cnt_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      if (tick && (state_q == FEND)) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end
      if (underrun_evt) begin
        underrun_q <= 1'b1;
      end
    end
  end

  assign o_pix_clk     = pix_clk_q;
  assign o_vsync       = vsync_q;
  assign o_hsync       = hsync_q;
  assign o_pix_data    = data_q;
  assign o_busy        = busy_q;
  assign o_underrun    = underrun_q;
  assign o_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_sf_camera_tx.sv
// Directed bench for sf_camera_tx (BUFFER_SIZE=4: 16-word buffer, 8-word block).
// A tick monitor records bytes, hblank gaps and vblank length; the main
// sequence compares them against hand-computed values.
module tb_sf_camera_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        reset_counts = 1'b0;
  logic [15:0] bytes_per_row = '0;
  logic [15:0] rows_per_frame = '0;
  logic [15:0] hblank = '0;
  logic [15:0] vblank = '0;
  logic        test_pattern = 1'b0;
  logic        busy;
  logic        underrun;
  logic [31:0] frame_count;
  logic        wfifo_ready;
  logic        wfifo_activate = 1'b0;
  logic        wfifo_strobe = 1'b0;
  logic [31:0] wfifo_data = '0;
  logic [23:0] wfifo_size;
  logic        pix_clk;
  logic        vsync;
  logic        hsync;
  logic [7:0]  pix_data;

  int n_checks = 0;
  int n_fail = 0;

  // Monitor state (written only by the monitor process)
  logic [7:0] q_bytes [$];
  int         q_hgap [$];
  int         tick_cnt = 0;
  int         hgap_run = 0;
  int         busy_tick = 0;
  int         vsync_tick = 0;
  logic       busy_prev = 1'b0;
  logic       vsync_prev = 1'b0;

  sf_camera_tx #(
    .BUFFER_SIZE(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_enable         (enable),
    .i_reset_counts   (reset_counts),
    .i_bytes_per_row  (bytes_per_row),
    .i_rows_per_frame (rows_per_frame),
    .i_hblank         (hblank),
    .i_vblank         (vblank),
    .i_test_pattern   (test_pattern),
    .o_busy           (busy),
    .o_underrun       (underrun),
    .o_frame_count    (frame_count),
    .o_wfifo_ready    (wfifo_ready),
    .i_wfifo_activate (wfifo_activate),
    .i_wfifo_strobe   (wfifo_strobe),
    .i_wfifo_data     (wfifo_data),
    .o_wfifo_size     (wfifo_size),
    .o_pix_clk        (pix_clk),
    .o_vsync          (vsync),
    .o_hsync          (hsync),
    .o_pix_data       (pix_data)
  );

  always #5 clk = ~clk;

  // Sample the bus once per tick (pixel clock just went low).
  always @(negedge clk) begin
    if (!rst && !pix_clk) begin
      tick_cnt <= tick_cnt + 1;
      if (hsync) begin
        q_bytes.push_back(pix_data);
        if (hgap_run != 0) q_hgap.push_back(hgap_run);
        hgap_run <= 0;
      end else if (vsync) begin
        hgap_run <= hgap_run + 1;
      end else begin
        hgap_run <= 0;
      end
      if (busy && !busy_prev) busy_tick <= tick_cnt + 1;
      if (vsync && !vsync_prev) vsync_tick <= tick_cnt + 1;
      busy_prev  <= busy;
      vsync_prev <= vsync;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic sig_val(input int sel);
    case (sel)
      0:       return busy;
      1:       return hsync;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic lvl, input int limit);
    int n = 0;
    while (sig_val(sel) !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sig_val(sel)), 32'(lvl));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_words(input logic [31:0] first, input int n, input logic [31:0] step,
                            input logic hold);
    @(negedge clk);
    wfifo_activate = 1'b1;
    for (int k = 0; k < n; k++) begin
      wfifo_data   = first + step * k;
      wfifo_strobe = 1'b1;
      @(negedge clk);
    end
    wfifo_strobe = 1'b0;
    if (!hold) wfifo_activate = 1'b0;
  endtask

  task automatic set_geom(input logic [15:0] bpr, input logic [15:0] rows,
                          input logic [15:0] hb, input logic [15:0] vb, input logic tp);
    bytes_per_row  = bpr;
    rows_per_frame = rows;
    hblank         = hb;
    vblank         = vb;
    test_pattern   = tp;
  endtask

  task automatic run_frame(input string tag);
    @(negedge clk);
    enable = 1'b1;
    wait_for({tag, "_start"}, 0, 1'b1, 20);
    enable = 1'b0;
    wait_for({tag, "_done"}, 0, 1'b0, 1000);
  endtask

  int base;
  int hbase;
  logic [7:0] tp_exp [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h01, 8'h00, 8'h03, 8'h02};
  logic [7:0] w_exp [4]  = '{8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd0);
    check("rst_data", 32'(pix_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_frames", frame_count, 32'd0);
    check("rst_pixclk", 32'(pix_clk), 32'd0);
    check("wfifo_size", 32'(wfifo_size), 32'd8);
    check("rst_ready", 32'(wfifo_ready), 32'd1);
    rst = 1'b0;

    // Reset in the middle of a row aborts everything
    push_words(32'h00010203, 4, 32'h04040404, 1'b0);
    set_geom(16'd8, 16'd2, 16'd3, 16'd2, 1'b0);
    enable = 1'b1;
    wait_for("midrow_hsync", 1, 1'b1, 200);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_vsync", 32'(vsync), 32'd0);
    check("midrst_hsync", 32'(hsync), 32'd0);
    check("midrst_data", 32'(pix_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(wfifo_ready), 32'd1);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_empty_nostart", 32'(busy), 32'd0);
    enable = 1'b0;

    // Basic two-row frame
    push_words(32'h00010203, 4, 32'h04040404, 1'b0);
    base  = q_bytes.size();
    hbase = q_hgap.size();
    set_geom(16'd8, 16'd2, 16'd3, 16'd2, 1'b0);
    run_frame("f1");
    check("f1_nbytes", 32'(q_bytes.size() - base), 32'd16);
    for (int i = 0; i < 16; i++) check($sformatf("f1_byte%0d", i), 32'(q_bytes[base + i]), 32'(i));
    check("f1_ngaps", 32'(q_hgap.size() - hbase), 32'd1);
    if (q_hgap.size() > hbase) check("f1_hblank", 32'(q_hgap[hbase]), 32'd3);
    check("f1_vblank", 32'(vsync_tick - busy_tick), 32'd2);
    check("f1_frames", frame_count, 32'd1);
    check("f1_underrun", 32'(underrun), 32'd0);
    check("f1_vsync_low", 32'(vsync), 32'd0);

    // One word short: last word of row 1 underruns
    push_words(32'h00010203, 3, 32'h04040404, 1'b0);
    base = q_bytes.size();
    run_frame("f2");
    check("f2_nbytes", 32'(q_bytes.size() - base), 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("f2_byte%0d", i), 32'(q_bytes[base + i]), (i < 12) ? 32'(i) : 32'd0);
    check("f2_underrun", 32'(underrun), 32'd1);
    check("f2_frames", frame_count, 32'd2);
    @(negedge clk);
    reset_counts = 1'b1;
    @(negedge clk);
    reset_counts = 1'b0;
    check("clr_underrun", 32'(underrun), 32'd0);
    check("clr_frames", frame_count, 32'd0);

    // Write-handshake readiness
    push_words(32'hA0A1A2A3, 8, 32'h0, 1'b1);
    check("fill_active_ready", 32'(wfifo_ready), 32'd0);
    wfifo_activate = 1'b0;
    @(negedge clk);
    check("half_ready", 32'(wfifo_ready), 32'd1);
    push_words(32'hB0B1B2B3, 1, 32'h0, 1'b0);
    @(negedge clk);
    check("nine_notready", 32'(wfifo_ready), 32'd0);
    base = q_bytes.size();
    set_geom(16'd4, 16'd1, 16'd1, 16'd1, 1'b0);
    run_frame("f3");
    for (int i = 0; i < 4; i++)
      check($sformatf("f3_byte%0d", i), 32'(q_bytes[base + i]), 32'(8'hA0 + i));
    check("f3_ready_after_pop", 32'(wfifo_ready), 32'd1);

    // Enable dropped during row 0: frame completes, no new frame
    do_reset();
    push_words(32'h10111213, 8, 32'h04040404, 1'b0);
    base = q_bytes.size();
    set_geom(16'd8, 16'd2, 16'd1, 16'd1, 1'b0);
    enable = 1'b1;
    wait_for("f4_row0", 1, 1'b1, 100);
    enable = 1'b0;
    wait_for("f4_done", 0, 1'b0, 1000);
    check("f4_nbytes", 32'(q_bytes.size() - base), 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("f4_byte%0d", i), 32'(q_bytes[base + i]), 32'(8'h10 + i));
    check("f4_frames", frame_count, 32'd1);
    repeat (40) @(negedge clk);
    check("f4_stays_idle", 32'(busy), 32'd0);
    check("f4_frames_hold", frame_count, 32'd1);

`ifdef SF_CAMERA_TX_TEST_PATTERN_EN
    // Generated data leaves the buffer untouched
    do_reset();
    push_words(32'h55667788, 1, 32'h0, 1'b0);
    base = q_bytes.size();
    set_geom(16'd4, 16'd2, 16'd1, 16'd1, 1'b1);
    run_frame("tp");
    check("tp_nbytes", 32'(q_bytes.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("tp_byte%0d", i), 32'(q_bytes[base + i]), 32'(tp_exp[i]));
    check("tp_underrun", 32'(underrun), 32'd0);
    base = q_bytes.size();
    set_geom(16'd4, 16'd1, 16'd1, 16'd1, 1'b0);
    run_frame("tpbuf");
    for (int i = 0; i < 4; i++) check($sformatf("tpbuf_byte%0d", i), 32'(q_bytes[base + i]), 32'(w_exp[i]));
    check("tpbuf_underrun", 32'(underrun), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
